chase_step_ctrl: RTL and testbench
==================================

Name: chase_step_ctrl

Overview:
- Input-conditioning stage directly upstream of the LED chase pattern generator.
- Synchronises and debounces the board buttons and turns presses into pause, speed and direction controls.
- Generates a one-cycle step_tick enable at a selectable rate. The chase stage advances one position per tick, in the direction given by dir, instead of deriving its own slow clock.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a new button level (10 ms at 25 MHz).
- PERIOD_MIN, 262144: step period in clk_25mhz cycles at the fastest speed (speed=7).
- SPEED_RESET, 4: speed value loaded on reset. At the defaults this gives 2^21 cycles, about 12 Hz.

Ports:
- clk_25mhz  input  1  system clock, 25 MHz
- rst  input  1  synchronous reset, active-high
- btn  input  7  raw asynchronous buttons, active-high; btn[0] unused, btn[1] pause toggle, btn[3] speed up, btn[4] speed down, btn[5] left, btn[6] right
- step_tick  output  1  one-cycle pulse; the chase advances one position
- dir  output  1  0 = ascending LED index, 1 = descending
- speed  output  3  current speed, 0 = slowest, 7 = fastest
- paused  output  1  1 = step_tick suppressed

Behaviour:
- Reset: one clock, synchronous, active-high; the polarity and synchronicity are fixed.
  - All state clears on any rst cycle, including mid-debounce and mid-period.
  - Reset values: step_tick=0, dir=0, speed=SPEED_RESET, paused=0.
  - Prescaler, debounce counters, synchroniser flops and debounced levels all clear to 0.
  - No press events are produced in the cycle after reset deasserts.
- Synchroniser: each btn bit passes through 2 flops before any use.
- Debounce, per button:
  - Keep a stable level and a counter.
  - While the synchronised input differs from the stable level, the counter increments; at DEBOUNCE_CYCLES it flips the stable level and clears.
  - Any cycle where the input equals the stable level clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES produce no change.
- Press event: a one-cycle internal pulse on a 0->1 transition of the stable level. Releases produce nothing. Holding a button produces exactly one event.
- Event effects, registered, visible the cycle after the press event:
  - pause: paused <= ~paused.
  - up: speed <= min(speed+1, 7). Saturates; no wrap.
  - down: speed <= max(speed-1, 0). Saturates.
  - up and down in the same cycle: speed unchanged.
  - right: dir <= 0. Left: dir <= 1. Both in the same cycle: dir unchanged.
  - Any accepted speed change, including a saturated no-op, clears the prescaler to 0.
- Prescaler:
  - 32-bit counter; period P = PERIOD_MIN << (7 - speed).
  - While paused=0: if counter == P-1, counter <= 0 and step_tick <= 1 next cycle; otherwise counter+1 and step_tick <= 0.
  - While paused=1: counter holds and step_tick=0.
  - On unpause, counting resumes from the held value, so the period is not restarted.
  - step_tick is registered and exactly one cycle wide. Ticks are spaced exactly P cycles apart in steady state.
- Simultaneous events:
  - A pause press and a terminal count in the same cycle: the tick is still issued, then the counter holds.
  - A speed change and a terminal count in the same cycle: the tick is issued and the counter clears.
- Widths: the P computation must not overflow 32 bits for the default parameters (max 2^25).

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, PERIOD_MIN=8, SPEED_RESET=4.
- Reset, then idle 200 cycles -> speed=4, dir=0, paused=0; step_tick pulses every 64 cycles, each 1 cycle wide. Asserting rst mid-period -> step_tick=0, and the next tick comes 64 cycles after deassertion.
- btn[3] bounce: three 2-cycle highs, then held 20 cycles -> exactly one increment, speed=5, tick spacing 32. Four more held presses -> speed=7, spacing 8; a further press -> speed stays 7.
- btn[4] pressed 7 times from speed 7 -> speed=0, spacing 1024; an eighth press -> speed stays 0, prescaler cleared.
- btn[1] press at cycle 40 of a 64-cycle period -> paused=1, no ticks for 500 cycles. Second press -> paused=0; the first tick arrives about 24 cycles later, per the held count.
- btn[5] press -> dir=1; btn[6] press -> dir=0. btn[5] and btn[6] pressed on the same cycle -> dir unchanged.
- btn[3] and btn[4] with identical stable-high timing -> speed unchanged. btn[0] toggling -> no effect on any output.

Source files
------------

// File: rtl/chase_step_ctrl.sv
// Input conditioning for the LED chase stage: button synchronise/debounce, pause,
// speed and direction control, and a rate-selectable one-cycle step_tick enable.
module chase_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned PERIOD_MIN      = 262144,
  parameter int unsigned SPEED_RESET     = 4
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic [6:0] btn,
  output logic       step_tick,
  output logic       dir,
  output logic [2:0] speed,
  output logic       paused
);

  localparam int unsigned     DB_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ZERO     = DB_W'(0);
  localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);
  localparam logic [2:0]      SPEED_INIT  = 3'(SPEED_RESET);
  localparam logic [31:0]     PERIOD_BASE = 32'(PERIOD_MIN);

  logic [6:0]      sync1_r;
  logic [6:0]      sync2_r;
  logic [6:0]      stable_r;
  logic [6:0]      stable_prev_r;
  logic [DB_W-1:0] db_cnt_r [7];
  logic [6:0]      press_s;
  logic            unused_press_s;

  logic            pause_evt_s;
  logic            up_evt_s;
  logic            down_evt_s;
  logic            left_evt_s;
  logic            right_evt_s;
  logic            speed_evt_s;
  logic            terminal_s;

  logic [2:0]      speed_r;
  logic [2:0]      speed_nxt_s;
  logic            dir_r;
  logic            dir_nxt_s;
  logic            paused_r;
  logic            paused_nxt_s;
  logic            tick_r;
  logic            tick_nxt_s;
  logic [31:0]     presc_r;
  logic [31:0]     presc_run_s;
  logic [31:0]     presc_nxt_s;
  logic [31:0]     period_s;

  // Two-flop synchroniser on every raw button bit.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      sync1_r <= 7'd0;
      sync2_r <= 7'd0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Per-button debounce: the stable level flips only after DEBOUNCE_CYCLES differing cycles.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      stable_r      <= 7'd0;
      stable_prev_r <= 7'd0;
      for (int i = 0; i < 7; i++) begin
        db_cnt_r[i] <= DB_ZERO;
      end
    end else begin
      stable_prev_r <= stable_r;
      for (int i = 0; i < 7; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          stable_r[i] <= ~stable_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Rising edge of the stable level is the press event; btn[0] and btn[2] carry no function.
  assign press_s        = stable_r & ~stable_prev_r;
  assign unused_press_s = press_s[0] ^ press_s[2];

  // Next-state decode for the control registers and the prescaler.
  always_comb begin
    pause_evt_s = press_s[1];
    up_evt_s    = press_s[3];
    down_evt_s  = press_s[4];
    left_evt_s  = press_s[5];
    right_evt_s = press_s[6];
    speed_evt_s = up_evt_s ^ down_evt_s;

    speed_nxt_s = speed_r;
    if (up_evt_s && !down_evt_s) begin
      if (speed_r == 3'd7) begin
        speed_nxt_s = 3'd7;
      end else begin
        speed_nxt_s = speed_r + 3'd1;
      end
    end else if (down_evt_s && !up_evt_s) begin
      if (speed_r == 3'd0) begin
        speed_nxt_s = 3'd0;
      end else begin
        speed_nxt_s = speed_r - 3'd1;
      end
    end else begin
      speed_nxt_s = speed_r;
    end

    dir_nxt_s = dir_r;
    if (left_evt_s && !right_evt_s) begin
      dir_nxt_s = 1'b1;
    end else if (right_evt_s && !left_evt_s) begin
      dir_nxt_s = 1'b0;
    end else begin
      dir_nxt_s = dir_r;
    end

    paused_nxt_s = paused_r ^ pause_evt_s;

    // The current-cycle paused value governs the count, so a pause press on the
    // terminal cycle still issues its tick before the counter freezes.
    period_s   = PERIOD_BASE << (3'd7 - speed_r);
    terminal_s = (presc_r == (period_s - 32'd1));
    if (paused_r) begin
      presc_run_s = presc_r;
      tick_nxt_s  = 1'b0;
    end else if (terminal_s) begin
      presc_run_s = 32'd0;
      tick_nxt_s  = 1'b1;
    end else begin
      presc_run_s = presc_r + 32'd1;
      tick_nxt_s  = 1'b0;
    end

    if (speed_evt_s) begin
      presc_nxt_s = 32'd0;
    end else begin
      presc_nxt_s = presc_run_s;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      speed_r  <= SPEED_INIT;
      dir_r    <= 1'b0;
      paused_r <= 1'b0;
      tick_r   <= 1'b0;
      presc_r  <= 32'd0;
    end else begin
      speed_r  <= speed_nxt_s;
      dir_r    <= dir_nxt_s;
      paused_r <= paused_nxt_s;
      tick_r   <= tick_nxt_s;
      presc_r  <= presc_nxt_s;
    end
  end

  assign step_tick = tick_r;
  assign dir       = dir_r;
  assign speed     = speed_r;
  assign paused    = paused_r;

endmodule

// File: tb/tb_chase_step_ctrl.sv
// Directed bench for chase_step_ctrl with small debounce/period parameters;
// expected values are queued with each stimulus step and popped at each check.
module tb_chase_step_ctrl;

  logic       clk_25mhz = 1'b0;
  logic       rst;
  logic [6:0] btn;
  logic       step_tick;
  logic       dir;
  logic [2:0] speed;
  logic       paused;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];

  chase_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PERIOD_MIN     (8),
    .SPEED_RESET    (4)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst      (rst),
    .btn      (btn),
    .step_tick(step_tick),
    .dir      (dir),
    .speed    (speed),
    .paused   (paused)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_assert++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
    end else begin
      exp_v = 32'hxxxx_xxxx;
    end
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic press(input logic [6:0] mask, input int hold);
    btn = mask;
    cyc(hold);
    btn = 7'd0;
    cyc(12);
  endtask

  // Counts negedges until step_tick is seen (always advances at least one).
  task automatic wait_tick(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk_25mhz);
      k++;
    end while (!step_tick && k < limit);
  endtask

  task automatic measure(input string tag, input int exp_p);
    int k;
    wait_tick(4000, k);
    @(negedge clk_25mhz);
    expect_val(32'd0);
    check({tag, " width"}, {31'd0, step_tick});
    wait_tick(4000, k);
    expect_val(32'(exp_p));
    check({tag, " spacing"}, 32'(k + 1));
  endtask

  // Drives btn from the current negedge, releases after 20 cycles, counts to the next tick.
  task automatic press_to_tick(input logic [6:0] mask, input int limit, output int k);
    btn = mask;
    k = 0;
    do begin
      @(negedge clk_25mhz);
      k++;
      if (k == 20) btn = 7'd0;
    end while (!step_tick && k < limit);
    btn = 7'd0;
    cyc(12);
  endtask

  initial begin
    int k;
    int ticks;
    rst = 1'b1;
    btn = 7'd0;
    cyc(3);
    expect_val(32'd0); check("rst tick", {31'd0, step_tick});
    expect_val(32'd4); check("rst speed", {29'd0, speed});
    expect_val(32'd0); check("rst dir", {31'd0, dir});
    expect_val(32'd0); check("rst paused", {31'd0, paused});
    rst = 1'b0;

    cyc(200);
    expect_val(32'd4); check("idle speed", {29'd0, speed});
    expect_val(32'd0); check("idle dir", {31'd0, dir});
    expect_val(32'd0); check("idle paused", {31'd0, paused});
    measure("spd4", 64);

    // Reset lands on the edge that would have ticked.
    wait_tick(4000, k);
    cyc(63);
    rst = 1'b1;
    @(negedge clk_25mhz);
    expect_val(32'd0); check("midrst tick", {31'd0, step_tick});
    rst = 1'b0;
    wait_tick(4000, k);
    expect_val(32'd64); check("midrst first tick", 32'(k));

    for (int i = 0; i < 3; i++) begin
      btn = 7'b0001000;
      cyc(2);
      btn = 7'd0;
      cyc(2);
    end
    press(7'b0001000, 20);
    expect_val(32'd5); check("bounce speed", {29'd0, speed});
    measure("spd5", 32);

    for (int i = 0; i < 4; i++) press(7'b0001000, 20);
    expect_val(32'd7); check("up speed", {29'd0, speed});
    measure("spd7", 8);
    press(7'b0001000, 20);
    expect_val(32'd7); check("up sat", {29'd0, speed});

    for (int i = 0; i < 7; i++) press(7'b0010000, 20);
    expect_val(32'd0); check("down speed", {29'd0, speed});
    measure("spd0", 1024);

    // Saturated press 100 cycles into a period still clears the prescaler.
    wait_tick(4000, k);
    cyc(100);
    press_to_tick(7'b0010000, 2000, k);
    expect_val(32'd1031); check("down sat clear", 32'(k));
    expect_val(32'd0); check("down sat", {29'd0, speed});

    for (int i = 0; i < 4; i++) press(7'b0001000, 20);
    expect_val(32'd4); check("back speed", {29'd0, speed});
    measure("spd4b", 64);

    // Pause takes effect on cycle 40 of the period.
    wait_tick(4000, k);
    cyc(33);
    btn = 7'b0000010;
    ticks = 0;
    for (int i = 1; i <= 520; i++) begin
      @(negedge clk_25mhz);
      if (i == 20) btn = 7'd0;
      if (step_tick) ticks++;
    end
    expect_val(32'd0); check("paused ticks", 32'(ticks));
    expect_val(32'd1); check("paused", {31'd0, paused});
    press_to_tick(7'b0000010, 500, k);
    expect_val(32'd31); check("resume tick", 32'(k));
    expect_val(32'd0); check("unpaused", {31'd0, paused});

    press(7'b1100000, 20);
    expect_val(32'd0); check("dir both0", {31'd0, dir});
    press(7'b0100000, 20);
    expect_val(32'd1); check("dir left", {31'd0, dir});
    press(7'b1100000, 20);
    expect_val(32'd1); check("dir both1", {31'd0, dir});
    press(7'b1000000, 20);
    expect_val(32'd0); check("dir right", {31'd0, dir});

    press(7'b0011000, 20);
    expect_val(32'd4); check("updown speed", {29'd0, speed});

    for (int i = 0; i < 30; i++) begin
      btn[0] = ~btn[0];
      cyc((i % 7) + 1);
    end
    btn = 7'd0;
    cyc(12);
    expect_val(32'd4); check("btn0 speed", {29'd0, speed});
    expect_val(32'd0); check("btn0 dir", {31'd0, dir});
    expect_val(32'd0); check("btn0 paused", {31'd0, paused});
    measure("btn0 spd4", 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
